i2cmb_xfer_sequencer: RTL and testbench
=======================================

# i2cmb_xfer_sequencer

Synthesizable Wishbone master that sits directly upstream of the `iicmb_m_wb` I2C multi-bus controller and drives its 2-bit-address/8-bit-data Wishbone slave port. It accepts one I2C transfer request at a time: bus select, 7-bit target address, direction and length. It then issues the full register-level command sequence: enable, Set Bus, Start, address byte, data bytes, Stop. Each command's completion is taken from `irq_i` followed by a CMDR status read. Write bytes come in on a ready/valid stream, read bytes go out on a valid stream, and each transfer ends with a one-cycle `done` pulse carrying a 2-bit status.

## Interface
- `LEN_W`, 8: width of `req_len`; max transfer length is 2^LEN_W-1 bytes.
- `BUS_W`, 4: width of `req_bus`; selects buses 0..2^BUS_W-1.
- `TIMEOUT_CYC`, 2000000: maximum `clk_i` cycles spent waiting for `irq_i` per command.

- `clk_i` in 1: system clock; everything is on its rising edge.
- `rst_i` in 1: reset, **synchronous, active-low**.
- `req_valid` in 1: transfer request valid.
- `req_ready` out 1: high only in IDLE.
- `req_bus` in BUS_W: I2C bus index.
- `req_addr` in 7: I2C target address.
- `req_rnw` in 1: 1 = read, 0 = write.
- `req_len` in LEN_W: byte count; 0 = address-only probe.
- `wdata` in 8: write byte.
- `wdata_valid` in 1: write byte valid.
- `wdata_ready` out 1: write byte accepted.
- `rdata` out 8: read byte.
- `rdata_valid` out 1: one-cycle strobe per read byte.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: 00 OK, 01 NAK, 10 arbitration lost, 11 timeout/error. Held until the next `done`.
- `cyc_o`, `stb_o`, `we_o` out 1 each: Wishbone master controls.
- `adr_o` out 2: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR.
- `dat_o` out 8: Wishbone write data.
- `dat_i` in 8: Wishbone read data.
- `ack_i` in 1: Wishbone acknowledge.
- `irq_i` in 1: controller interrupt request (level).

## Operation
- **Handshake.** A request is accepted on `req_valid && req_ready`. All `req_*` fields are latched. `req_ready` drops the next cycle.
- **Enable step.** The sequencer keeps an internal `enabled` flag.
  - If it is clear: write CSR=0xC0 (E|IE), then set the flag.
  - The flag is cleared by reset and by a timeout.
- **Command step.** Each step is either (a) a DPR write followed by a CMDR write, or (b) a CMDR write alone. It is then followed by:
  - IRQ_WAIT until `irq_i`=1;
  - a CMDR read, which clears the irq in the controller.
  - Status bits: DON=bit7, NAK=bit6, AL=bit5, ERR=bit4.
- **Command sequence.**
  - DPR=bus, CMDR=0x06 (Set Bus).
  - CMDR=0x04 (Start).
  - DPR={addr,rnw}, CMDR=0x01 (Write).
  - Then `req_len` data steps:
    - Write step: wait in WDATA until `wdata_valid`, pulse `wdata_ready` one cycle, capture the byte, then DPR=byte and CMDR=0x01.
    - Read step: CMDR=0x02 (read with ACK), or 0x03 (read with NAK) on the last byte. After the status read, a DPR read returns the byte on `rdata`, with `rdata_valid` pulsed the cycle after that read's ack.
  - CMDR=0x05 (Stop).
  - Then `done`.
- **Status handling after each CMDR read.**
  - DON: continue.
  - NAK (address or write data): skip remaining data and go to Stop, final status 01.
  - AL: go straight to `done` with status 10; no Stop is issued.
  - ERR: go to Stop, status 11.
  - If more than one bit is set, priority is AL > ERR > NAK > DON.
- **Timeout.** The IRQ_WAIT counter is reset on entry. If it reaches TIMEOUT_CYC:
  - write CSR=0x00;
  - clear `enabled`;
  - pulse `done` with status 11.
- **States.** IDLE, EN, WB_ACC (generic access sub-FSM), IRQ_WAIT, STAT_RD, WDATA, RD_DPR, STOP, ABORT_DIS, DONE.
- **Byte counter.** Width LEN_W, loaded from `req_len`, decremented after each data step. Zero means go to Stop.
- **Reset mid-transfer.** Return to IDLE and drop `cyc_o`/`stb_o` in the same cycle. No `done` pulse, and `enabled` is cleared.

## Timing
- **Reset values.**
  - `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o`, `wdata_ready`, `rdata_valid`, `done`, `rdata` = 0.
  - `status` = 00.
  - `req_ready` = 0 during reset and 1 from the first cycle after release.
- **Wishbone access.**
  - `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o` are registered and held until the cycle `ack_i` is sampled 1.
  - All of them deassert the following cycle.
  - At least one idle cycle separates consecutive accesses.
  - Read data is captured from `dat_i` on the ack cycle.
- **Latency.**
  - The first `cyc_o` rises the cycle after request acceptance.
  - `done` rises one cycle after the final Stop status read completes. For AL it rises one cycle after the AL status read.
- **Wait behaviour.** IRQ_WAIT samples `irq_i` each cycle; the CMDR read starts the next cycle. There is no access timeout on `ack_i`: the sequencer waits indefinitely.
- **Next request.** `req_ready` re-asserts the cycle after `done`.

## Test plan
- **2-byte write.** Reset, then request bus=5, addr=0x22, write, len=2, data 0xA5,0x3C.
  - Wishbone writes, in order: CSR←0xC0, DPR←0x05, CMDR←0x06, CMDR←0x04, DPR←0x44, CMDR←0x01, DPR←0xA5, CMDR←0x01, DPR←0x3C, CMDR←0x01, CMDR←0x05.
  - `done` with status 00.
- **3-byte read.** Bus=15, addr=0x10, read, len=3; the slave returns 0x01,0x02,0x03.
  - Read commands issued: CMDR←0x02, 0x02, 0x03.
  - Three `rdata_valid` pulses carrying 0x01, 0x02, 0x03.
  - No CSR write, since `enabled` is already set.
- **Address NAK.** The address status read returns 0xC0.
  - No data steps; CMDR←0x05 is issued; `done` with status 01.
- **Arbitration lost.** Status 0xA0 returned after Start.
  - `done` with status 10 and no Stop write.
- **Timeout and re-enable.** `irq_i` held 0 with TIMEOUT_CYC=100.
  - CSR←0x00 after 100 wait cycles; `done` with status 11.
  - The next request begins with CSR←0xC0.
- **Reset mid-write.** `rst_i`=0 while in WDATA.
  - Next cycle: `cyc_o`=0, no `done`, `req_ready`=1 after release.

Source files
------------

// File: rtl/i2cmb_xfer_sequencer.sv
// i2cmb_xfer_sequencer
//   Wishbone master that runs one complete I2C transfer on an iicmb_m_wb
//   controller: enable, Set Bus, Start, address, data bytes, Stop.
//   Command completion is taken from irq_i followed by a CMDR status read.
// Ports
//   clk_i, rst_i                      clock, synchronous active-low reset
//   req_valid/req_ready/req_*         transfer request (bus, addr, rnw, len)
//   wdata/wdata_valid/wdata_ready     write byte stream
//   rdata/rdata_valid                 read byte strobe
//   done/status                       completion pulse, 00 OK 01 NAK 10 AL 11 err
//   cyc_o stb_o we_o adr_o dat_o      Wishbone master outputs
//   dat_i ack_i irq_i                 Wishbone inputs, controller interrupt
module i2cmb_xfer_sequencer #(
    parameter int LEN_W       = 8,
    parameter int BUS_W       = 4,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [BUS_W-1:0] req_bus,
    input  logic [6:0]       req_addr,
    input  logic             req_rnw,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             done,
    output logic [1:0]       status,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [1:0]       adr_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    input  logic             ack_i,
    input  logic             irq_i
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;
    localparam logic [7:0] CMD_WRITE = 8'h01, CMD_RDACK = 8'h02, CMD_RDNAK = 8'h03,
                           CMD_START = 8'h04, CMD_STOP  = 8'h05, CMD_SETBUS = 8'h06;

    typedef enum logic [3:0] {
        S_IDLE, S_EN, S_CMD, S_WB_ACC, S_IRQ_WAIT, S_STAT_RD,
        S_WDATA, S_RD_DPR, S_STOP, S_ABORT_DIS, S_DONE
    } state_t;

    typedef enum logic [2:0] {P_BUS, P_START, P_ADDR, P_DATA, P_STOP} phase_t;

    state_t           r_state, r_ret;
    phase_t           r_phase;
    logic             r_enabled;
    logic [BUS_W-1:0] r_bus;
    logic [6:0]       r_addr;
    logic             r_rnw;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_cmd;
    logic [3:0]       r_stat;       // DON, NAK, AL, ERR from last CMDR read
    logic [1:0]       r_pend;       // status to report when the Stop completes
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_cyc, r_we;
    logic [1:0]       r_adr;
    logic [7:0]       r_dat;
    logic             r_req_ready, r_wdata_ready, r_rdata_valid, r_done;
    logic [7:0]       r_rdata;
    logic [1:0]       r_status;
    logic [LEN_W-1:0] w_cnt_nxt;

    // Bytes left once the current step is retired; the address step
    // does not consume a data byte.
    always_comb begin
        w_cnt_nxt = r_cnt - LEN_W'(1);
        if (r_state == S_STAT_RD && r_phase == P_ADDR) w_cnt_nxt = r_cnt;
    end

    function automatic state_t f_step(input logic [LEN_W-1:0] c, input logic rnw);
        if (c == '0) return S_STOP;
        else if (rnw) return S_CMD;
        else return S_WDATA;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;        r_ret <= S_IDLE;      r_phase <= P_BUS;
            r_enabled <= 1'b0;        r_bus <= '0;          r_addr <= 7'd0;
            r_rnw <= 1'b0;            r_cnt <= '0;          r_cmd <= 8'h00;
            r_stat <= 4'h0;           r_pend <= 2'b00;      r_to_cnt <= '0;
            r_cyc <= 1'b0;            r_we <= 1'b0;         r_adr <= 2'd0;
            r_dat <= 8'h00;           r_req_ready <= 1'b0;  r_wdata_ready <= 1'b0;
            r_rdata_valid <= 1'b0;    r_done <= 1'b0;       r_rdata <= 8'h00;
            r_status <= 2'b00;
        end else begin
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_wdata_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_bus <= req_bus; r_addr <= req_addr; r_rnw <= req_rnw;
                        r_cnt <= req_len; r_pend <= 2'b00;
                        r_phase <= P_BUS; r_cmd <= CMD_SETBUS;
                        r_cyc <= 1'b1; r_we <= 1'b1; r_state <= S_WB_ACC;
                        if (r_enabled) begin
                            r_adr <= A_DPR; r_dat <= 8'(req_bus); r_ret <= S_CMD;
                        end else begin
                            r_adr <= A_CSR; r_dat <= 8'hC0; r_ret <= S_EN;
                        end
                    end
                end
                S_EN: begin
                    r_enabled <= 1'b1;
                    r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= A_DPR; r_dat <= 8'(r_bus);
                    r_ret <= S_CMD; r_state <= S_WB_ACC;
                end
                S_CMD: begin
                    r_to_cnt <= '0;
                    r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= A_CMDR; r_dat <= r_cmd;
                    r_ret <= S_IRQ_WAIT; r_state <= S_WB_ACC;
                end
                S_WB_ACC: begin
                    if (ack_i) begin
                        r_cyc <= 1'b0; r_we <= 1'b0; r_adr <= 2'd0; r_dat <= 8'h00;
                        r_stat <= dat_i[7:4];
                        r_state <= r_ret;
                        if (r_ret == S_RD_DPR) begin
                            r_rdata <= dat_i; r_rdata_valid <= 1'b1;
                        end
                        // Terminal status reads finish here so done follows the ack directly.
                        if (r_ret == S_STAT_RD && (dat_i[5] || r_phase == P_STOP)) begin
                            r_done <= 1'b1; r_state <= S_DONE;
                            r_status <= dat_i[5] ? 2'b10 : (dat_i[4] ? 2'b11 : r_pend);
                        end
                    end
                end
                S_IRQ_WAIT: begin
                    if (irq_i) begin
                        r_cyc <= 1'b1; r_we <= 1'b0; r_adr <= A_CMDR;
                        r_ret <= S_STAT_RD; r_state <= S_WB_ACC;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= A_CSR; r_dat <= 8'h00;
                        r_ret <= S_ABORT_DIS; r_state <= S_WB_ACC;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_STAT_RD: begin
                    // r_stat = {DON, NAK, AL, ERR}; AL never reaches this state.
                    if (r_stat[0] || !r_stat[3]) begin
                        r_pend <= 2'b11; r_state <= S_STOP;
                    end else if (r_stat[2]) begin
                        r_pend <= 2'b01; r_state <= S_STOP;
                    end else begin
                        case (r_phase)
                            P_BUS: begin
                                r_phase <= P_START; r_cmd <= CMD_START; r_state <= S_CMD;
                            end
                            P_START: begin
                                r_phase <= P_ADDR; r_cmd <= CMD_WRITE;
                                r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= A_DPR;
                                r_dat <= {r_addr, r_rnw}; r_ret <= S_CMD; r_state <= S_WB_ACC;
                            end
                            default: begin
                                if (r_rnw && r_phase == P_DATA) begin
                                    r_cyc <= 1'b1; r_we <= 1'b0; r_adr <= A_DPR;
                                    r_ret <= S_RD_DPR; r_state <= S_WB_ACC;
                                end else begin
                                    r_cnt <= w_cnt_nxt; r_phase <= P_DATA;
                                    r_cmd <= (w_cnt_nxt == LEN_W'(1)) ? CMD_RDNAK : CMD_RDACK;
                                    r_state <= f_step(w_cnt_nxt, r_rnw);
                                end
                            end
                        endcase
                    end
                end
                S_WDATA: begin
                    // Ready is raised first; the byte is taken on valid && ready.
                    if (r_wdata_ready && wdata_valid) begin
                        r_cmd <= CMD_WRITE;
                        r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= A_DPR; r_dat <= wdata;
                        r_ret <= S_CMD; r_state <= S_WB_ACC;
                    end else if (wdata_valid) begin
                        r_wdata_ready <= 1'b1;
                    end
                end
                S_RD_DPR: begin
                    r_cnt <= w_cnt_nxt;
                    r_cmd <= (w_cnt_nxt == LEN_W'(1)) ? CMD_RDNAK : CMD_RDACK;
                    r_state <= f_step(w_cnt_nxt, r_rnw);
                end
                S_STOP: begin
                    r_phase <= P_STOP; r_cmd <= CMD_STOP; r_state <= S_CMD;
                end
                S_ABORT_DIS: begin
                    r_enabled <= 1'b0; r_done <= 1'b1; r_status <= 2'b11; r_state <= S_DONE;
                end
                S_DONE: begin
                    r_req_ready <= 1'b1; r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign wdata_ready = r_wdata_ready;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign status      = r_status;
    assign cyc_o       = r_cyc;
    assign stb_o       = r_cyc;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
endmodule

// File: tb/tb_i2cmb_xfer_sequencer.sv
module tb_i2cmb_xfer_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid = 1'b0, req_rnw = 1'b0;
    logic [3:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_len = '0;
    logic [7:0] wdata = '0;
    logic       wdata_valid = 1'b0, wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid, done;
    logic [1:0] status;
    logic       req_ready, cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0, irq_i = 1'b0;

    i2cmb_xfer_sequencer #(.LEN_W(8), .BUS_W(4), .TIMEOUT_CYC(100)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
        .req_bus(req_bus), .req_addr(req_addr), .req_rnw(req_rnw), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .status(status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    // Slave / stream model state
    logic [9:0] wlog[$];          // {adr, dat} of every acked write
    int         wcyc[$];
    logic [7:0] rlog[$];
    int         rvlat[$];
    logic [7:0] rdq[$];
    logic [7:0] wq[$];
    logic       wpop = 1'b0, ack_en = 1'b1, irq_en = 1'b1, ovr_on = 1'b0;
    logic [7:0] ovr_cmd = '0, ovr_stat = '0, pend_stat = 8'h80, tmp;
    int         irq_cnt = 0, ndone = 0, done_cyc = 0, last_st_cyc = 0, last_dpr_cyc = 0;
    logic [1:0] last_status = '0;
    logic       done_prev = 1'b0, rdy_after = 1'b0;

    always @(negedge clk) begin
        if (wpop) begin tmp = wq.pop_front(); wpop = 1'b0; end
        if (wq.size() > 0) begin wdata_valid = 1'b1; wdata = wq[0]; wpop = wdata_ready; end
        else wdata_valid = 1'b0;
        if (cyc_o && stb_o && !ack_i && ack_en) begin
            ack_i = 1'b1;
            if (we_o) begin
                wlog.push_back({adr_o, dat_o}); wcyc.push_back(cyc_n);
                if (adr_o == 2'd2) begin
                    pend_stat = (ovr_on && dat_o == ovr_cmd) ? ovr_stat : 8'h80;
                    if (irq_en) irq_cnt = 3;
                end
            end else if (adr_o == 2'd2) begin
                dat_i = pend_stat; irq_i = 1'b0; last_st_cyc = cyc_n;
            end else if (adr_o == 2'd1) begin
                dat_i = (rdq.size() > 0) ? rdq.pop_front() : 8'hEE; last_dpr_cyc = cyc_n;
            end else dat_i = 8'h00;
        end else ack_i = 1'b0;
        if (irq_cnt > 0) begin irq_cnt--; if (irq_cnt == 0) irq_i = 1'b1; end
        if (rdata_valid) begin rlog.push_back(rdata); rvlat.push_back(cyc_n - last_dpr_cyc); end
        if (done_prev) rdy_after = req_ready;
        done_prev = done;
        if (done) begin ndone++; last_status = status; done_cyc = cyc_n; end
    end

    task automatic send_req(input logic [3:0] b, input logic [6:0] a, input logic rnw,
                            input logic [7:0] len);
        int k = 0;
        @(negedge clk);
        req_bus = b; req_addr = a; req_rnw = rnw; req_len = len; req_valid = 1'b1;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL req_accept: req_ready stuck low"); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int n0 = ndone;
        int k = 0;
        while (ndone == n0 && k < lim) begin @(negedge clk); k++; end
        checks++;
        if (ndone == n0) begin errors++; $display("FAIL %s_done: none in %0d cycles", nm, lim); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 9;
        if (cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b want 0", cyc_o); end
        if (stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b want 0", stb_o); end
        if (we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we_o); end
        if ({adr_o, dat_o} !== 10'h000) begin errors++; $display("FAIL rst_adr_dat: got %h want 000", {adr_o, dat_o}); end
        if (wdata_ready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", wdata_ready); end
        if (rdata_valid !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %b/%h want 0/00", rdata_valid, rdata); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        if (status !== 2'b00) begin errors++; $display("FAIL rst_status: got %b want 00", status); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write();
        logic [9:0] exp[$];
        exp = '{10'h0C0, 10'h105, 10'h206, 10'h204, 10'h144, 10'h201,
                10'h1A5, 10'h201, 10'h13C, 10'h201, 10'h205};
        wlog.delete(); wcyc.delete(); wq = '{8'hA5, 8'h3C};
        @(negedge clk);
        req_bus = 4'd5; req_addr = 7'h22; req_rnw = 1'b0; req_len = 8'd2; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        checks += 2;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_drop: got %b want 0", req_ready); end
        if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== {3'b111, 10'h0C0})
            begin errors++; $display("FAIL wr_first_cyc: got %b%b%b %h want 111 0c0", cyc_o, stb_o, we_o, {adr_o, dat_o}); end
        wait_done(600, "wr");
        checks += 5;
        if (wlog.size() != exp.size()) begin errors++; $display("FAIL wr_count: got %0d want %0d", wlog.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= wlog.size() || wlog[i] !== exp[i])
                begin errors++; $display("FAIL wr_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 10'h3FF, exp[i]); end
        end
        if (last_status !== 2'b00) begin errors++; $display("FAIL wr_status: got %b want 00", last_status); end
        if (done_cyc - last_st_cyc != 1) begin errors++; $display("FAIL wr_done_lat: got %0d want 1", done_cyc - last_st_cyc); end
        if (rdy_after !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got %b want 1", rdy_after); end
        if (wq.size() != 0) begin errors++; $display("FAIL wr_bytes_taken: got %0d left want 0", wq.size()); end
    endtask

    task automatic test_read();
        logic [9:0] exp[$];
        logic [7:0] rexp[$];
        exp = '{10'h10F, 10'h206, 10'h204, 10'h121, 10'h201, 10'h202, 10'h202, 10'h203, 10'h205};
        rexp = '{8'h01, 8'h02, 8'h03};
        wlog.delete(); rlog.delete(); rvlat.delete(); rdq = '{8'h01, 8'h02, 8'h03};
        send_req(4'd15, 7'h10, 1'b1, 8'd3);
        wait_done(800, "rd");
        checks += 3;
        if (wlog.size() != exp.size()) begin errors++; $display("FAIL rd_count: got %0d want %0d", wlog.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= wlog.size() || wlog[i] !== exp[i])
                begin errors++; $display("FAIL rd_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 10'h3FF, exp[i]); end
        end
        if (rlog.size() != 3) begin errors++; $display("FAIL rd_nbytes: got %0d want 3", rlog.size()); end
        foreach (rexp[i]) begin
            checks += 2;
            if (i >= rlog.size() || rlog[i] !== rexp[i])
                begin errors++; $display("FAIL rd_byte[%0d]: got %h want %h", i, (i < rlog.size()) ? rlog[i] : 8'hXX, rexp[i]); end
            if (i >= rvlat.size() || rvlat[i] != 1)
                begin errors++; $display("FAIL rd_valid_lat[%0d]: got %0d want 1", i, (i < rvlat.size()) ? rvlat[i] : -1); end
        end
        if (last_status !== 2'b00) begin errors++; $display("FAIL rd_status: got %b want 00", last_status); end
    endtask

    task automatic test_addr_nak();
        logic [9:0] exp[$];
        exp = '{10'h101, 10'h206, 10'h204, 10'h1A0, 10'h201, 10'h205};
        wlog.delete(); ovr_on = 1'b1; ovr_cmd = 8'h01; ovr_stat = 8'hC0;
        send_req(4'd1, 7'h50, 1'b0, 8'd2);
        wait_done(600, "nak");
        ovr_on = 1'b0;
        checks += 2;
        if (wlog.size() != exp.size()) begin errors++; $display("FAIL nak_count: got %0d want %0d", wlog.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= wlog.size() || wlog[i] !== exp[i])
                begin errors++; $display("FAIL nak_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 10'h3FF, exp[i]); end
        end
        if (last_status !== 2'b01) begin errors++; $display("FAIL nak_status: got %b want 01", last_status); end
    endtask

    task automatic test_arb_lost();
        logic [9:0] exp[$];
        exp = '{10'h102, 10'h206, 10'h204};
        wlog.delete(); ovr_on = 1'b1; ovr_cmd = 8'h04; ovr_stat = 8'hA0;
        send_req(4'd2, 7'h33, 1'b1, 8'd1);
        checks++;
        if (status !== 2'b01) begin errors++; $display("FAIL al_status_held: got %b want 01", status); end
        wait_done(400, "al");
        ovr_on = 1'b0;
        checks += 3;
        if (wlog.size() != exp.size()) begin errors++; $display("FAIL al_count: got %0d want %0d", wlog.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= wlog.size() || wlog[i] !== exp[i])
                begin errors++; $display("FAIL al_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 10'h3FF, exp[i]); end
        end
        if (last_status !== 2'b10) begin errors++; $display("FAIL al_status: got %b want 10", last_status); end
        if (done_cyc - last_st_cyc != 1) begin errors++; $display("FAIL al_done_lat: got %0d want 1", done_cyc - last_st_cyc); end
    endtask

    task automatic test_timeout();
        logic [9:0] exp[$];
        logic [9:0] exp2[$];
        int gap;
        exp = '{10'h103, 10'h206, 10'h000};
        exp2 = '{10'h0C0, 10'h100, 10'h206, 10'h204, 10'h1FE, 10'h201, 10'h205};
        wlog.delete(); wcyc.delete(); irq_en = 1'b0;
        send_req(4'd3, 7'h0A, 1'b0, 8'd0);
        wait_done(400, "to");
        irq_en = 1'b1;
        gap = (wcyc.size() > 2) ? wcyc[2] - wcyc[1] : -1;
        checks += 3;
        if (wlog.size() != exp.size()) begin errors++; $display("FAIL to_count: got %0d want %0d", wlog.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= wlog.size() || wlog[i] !== exp[i])
                begin errors++; $display("FAIL to_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 10'h3FF, exp[i]); end
        end
        if (last_status !== 2'b11) begin errors++; $display("FAIL to_status: got %b want 11", last_status); end
        if (gap < 100 || gap > 102) begin errors++; $display("FAIL to_wait: got %0d cycles want 100..102", gap); end
        wlog.delete();
        send_req(4'd0, 7'h7F, 1'b0, 8'd0);
        wait_done(400, "reen");
        checks += 2;
        if (wlog.size() != exp2.size()) begin errors++; $display("FAIL reen_count: got %0d want %0d", wlog.size(), exp2.size()); end
        foreach (exp2[i]) begin
            checks++;
            if (i >= wlog.size() || wlog[i] !== exp2[i])
                begin errors++; $display("FAIL reen_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 10'h3FF, exp2[i]); end
        end
        if (last_status !== 2'b00) begin errors++; $display("FAIL reen_status: got %b want 00", last_status); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int n0;
        wlog.delete();
        send_req(4'd4, 7'h11, 1'b0, 8'd1);
        while (wlog.size() < 5 && k < 300) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        n0 = ndone;
        checks += 2;
        if (wlog.size() != 5) begin errors++; $display("FAIL rm_pre_count: got %0d want 5", wlog.size()); end
        if (wdata_ready !== 1'b1 && cyc_o !== 1'b0) begin errors++; $display("FAIL rm_pre_idle: cyc %b want 0", cyc_o); end
        rst_i = 1'b0;
        @(negedge clk);
        checks += 2;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin errors++; $display("FAIL rm_cyc: got %b%b want 00", cyc_o, stb_o); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_rst: got %b want 0", req_ready); end
        rst_i = 1'b1;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_rel: got %b want 1", req_ready); end
        if (ndone != n0) begin errors++; $display("FAIL rm_no_done: got %0d pulses want 0", ndone - n0); end
        // Reset while a Wishbone access is stalled; enable flag must also be gone.
        ack_en = 1'b0;
        send_req(4'd6, 7'h01, 1'b0, 8'd0);
        checks++;
        if ({cyc_o, we_o, adr_o, dat_o} !== {2'b11, 10'h0C0})
            begin errors++; $display("FAIL rm_reenable: got %b%b %h want 11 0c0", cyc_o, we_o, {adr_o, dat_o}); end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin errors++; $display("FAIL rm_acc_cyc: got %b%b want 00", cyc_o, stb_o); end
        rst_i = 1'b1; ack_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ndone != n0) begin errors++; $display("FAIL rm_acc_no_done: got %0d pulses want 0", ndone - n0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nak();
        test_arb_lost();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
